// File: rtl/juggle_pkg.sv
// juggle_pkg: shared widths, ball palette and renderer FSM states
package juggle_pkg;
    localparam int MAX_BALLS = 7;
    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam logic [11:0] BALL_COLOR [MAX_BALLS] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hFFF
    };
    typedef enum logic {BLANK, SHOW} state_t;
endpackage

// File: rtl/ball_renderer_if.sv
// ball_renderer_if: trajectory bus carrying ball centres and count into the renderer
interface ball_renderer_if;
    import juggle_pkg::*;
    logic [X_W-1:0] traj_x_in [MAX_BALLS-1:0];
    logic [Y_W-1:0] traj_y_in [MAX_BALLS-1:0];
    logic           traj_valid_in;
    logic [2:0]     num_balls_in;
    modport master (output traj_x_in, traj_y_in, traj_valid_in, num_balls_in);
    modport slave  (input  traj_x_in, traj_y_in, traj_valid_in, num_balls_in);
endinterface

// File: rtl/ball_hit_test.sv
// ball_hit_test: per-ball distance pipeline (deltas, gated squares, radius window compare)
module ball_hit_test
    import juggle_pkg::*;
#(
    parameter logic [11:0] RAD   = 12'd8,
    parameter logic [10:0] HI_SQ = 11'd64,
    parameter logic [10:0] LO_SQ = 11'd0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           active,
    input  logic [X_W-1:0] hcount,
    input  logic [Y_W-1:0] vcount,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           hit
);
    logic [11:0] dx, dy, adx, ady;
    logic        act_1, act_2, near;
    logic [9:0]  sq_x, sq_y;
    logic [10:0] sum;
    assign adx  = dx[11] ? ~dx + 12'd1 : dx;
    assign ady  = dy[11] ? ~dy + 12'd1 : dy;
    assign near = adx <= RAD && ady <= RAD;
    assign sum  = {1'b0, sq_x} + {1'b0, sq_y};
    assign hit  = act_2 && sum <= HI_SQ && sum >= LO_SQ;
    // stage 1: 12-bit two's-complement deltas so centres near an edge never wrap
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            act_1 <= 1'b0;
            dx    <= '0;
            dy    <= '0;
        end else begin
            act_1 <= active;
            dx    <= {1'b0, hcount} - {1'b0, x};
            dy    <= {2'b0, vcount} - {2'b0, y};
        end
    end
    // stage 2: out-of-box pixels miss outright; in-box magnitudes fit 5 bits for squaring
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            act_2 <= 1'b0;
            sq_x  <= '0;
            sq_y  <= '0;
        end else begin
            act_2 <= act_1 && near;
            sq_x  <= near ? 10'(adx[4:0]) * 10'(adx[4:0]) : '0;
            sq_y  <= near ? 10'(ady[4:0]) * 10'(ady[4:0]) : '0;
        end
    end
endmodule

// File: rtl/ball_renderer.sv
// ball_renderer: 3-stage pixel pipeline drawing up to 7 balls; BALL_OUTLINE_EN draws rings instead of discs
module ball_renderer
    import juggle_pkg::*;
#(
    parameter int RADIUS     = 8,
    parameter int RING_WIDTH = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              nf_in,
    input  logic [X_W-1:0]    hcount_in,
    input  logic [Y_W-1:0]    vcount_in,
    ball_renderer_if.slave    traj,
    output logic [11:0]       pixel_out,
    output logic              ball_hit_out,
    output logic [2:0]        ball_idx_out
);
`ifdef BALL_OUTLINE_EN
    localparam bit OUTLINE = 1'b1;
`else
    localparam bit OUTLINE = 1'b0;
`endif
    localparam int          INNER = RADIUS > RING_WIDTH ? RADIUS - RING_WIDTH : 0;
    localparam logic [10:0] HI_SQ = 11'(RADIUS * RADIUS);
    localparam logic [10:0] LO_SQ = OUTLINE ? 11'(INNER * INNER) : 11'd0;
    logic [X_W-1:0]       pend_x [MAX_BALLS-1:0];
    logic [Y_W-1:0]       pend_y [MAX_BALLS-1:0];
    logic [X_W-1:0]       disp_x [MAX_BALLS-1:0];
    logic [Y_W-1:0]       disp_y [MAX_BALLS-1:0];
    logic [2:0]           pend_n, disp_n, cur_n, sel;
    logic                 pend_ok, load, show;
    logic [11:0]          color;
    logic [MAX_BALLS-1:0] hit;
    state_t               state;
    assign load  = nf_in && pend_ok;
    assign show  = state == SHOW || load;
    assign cur_n = load ? pend_n : disp_n;
    // double buffering: pending tracks every valid trajectory, display swaps only at frame start
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= BLANK;
            pend_ok <= 1'b0;
            pend_n  <= '0;
            disp_n  <= '0;
            pend_x  <= '{default: '0};
            pend_y  <= '{default: '0};
            disp_x  <= '{default: '0};
            disp_y  <= '{default: '0};
        end else begin
            if (traj.traj_valid_in) begin
                pend_x  <= traj.traj_x_in;
                pend_y  <= traj.traj_y_in;
                pend_n  <= traj.num_balls_in;
                pend_ok <= 1'b1;
            end
            if (load) begin
                disp_x <= pend_x;
                disp_y <= pend_y;
                disp_n <= pend_n;
                state  <= SHOW;
            end
        end
    end
    // the pixel sampled on a load edge already sees the incoming display buffer
    for (genvar g = 0; g < MAX_BALLS; g++) begin : g_ball
        ball_hit_test #(
            .RAD   (12'(RADIUS)),
            .HI_SQ (HI_SQ),
            .LO_SQ (LO_SQ)
        ) u_hit (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .active (show && 3'(g) < cur_n),
            .hcount (hcount_in),
            .vcount (vcount_in),
            .x      (load ? pend_x[g] : disp_x[g]),
            .y      (load ? pend_y[g] : disp_y[g]),
            .hit    (hit[g])
        );
    end
    // priority encoder: lowest-index hitting ball wins
    always_comb begin
        sel   = 3'd7;
        color = '0;
        for (int i = MAX_BALLS - 1; i >= 0; i--) begin
            sel   = hit[i] ? 3'(i) : sel;
            color = hit[i] ? BALL_COLOR[i] : color;
        end
    end
    // stage 3: registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ball_hit_out <= 1'b0;
            ball_idx_out <= 3'd7;
            pixel_out    <= '0;
        end else begin
            ball_hit_out <= |hit;
            ball_idx_out <= sel;
            pixel_out    <= color;
        end
    end
endmodule
